pci_cfg_space: RTL and testbench
================================

// Module: pci_cfg_space
// PURPOSE
// - Parametrised type-0 PCI configuration space for the Edu device family; replaces the fixed read-only block.
// - Adds byte-enabled config writes, N memory BARs with sizing, W1C status bits, and multi-vector MSI (64-bit addr).
// - Sits between the PCI target state machine (dword cfg accesses) and the device core, which consumes BAR/command/MSI state.
// PARAMETERS
// - VENDOR_ID        16'h1234   read-only vendor ID
// - DEVICE_ID        16'h11e8   read-only device ID
// - REVISION         8'h0a      read-only revision ID
// - CLASS_CODE       24'hff0000 {class,subclass,progif}
// - NUM_BARS         1          implemented 32-bit non-prefetchable memory BARs, 1..6 (BAR0..BAR(n-1))
// - BAR_SIZE_LOG2    12         log2 of every BAR's window in bytes, 4..31
// - MSI_VECTORS_LOG2 0          Multiple Message Capable field, 0..5
// PORTS
// - clk                    in   1          clock
// - rst                    in   1          asynchronous, active-low reset
// - cfg_enable             in   1          access request, one access per cycle held high
// - cfg_iswrite            in   1          1 = write, 0 = read
// - cfg_offset             in   6          dword offset (0x00..0x3f)
// - cfg_byte_en            in   4          write byte enables, bit i = bits [8i+7:8i]
// - cfg_write_val          in   32         write data
// - cfg_read_val           out  32         registered read data, valid with cfg_ack
// - cfg_ack                out  1          1-cycle pulse, cycle after each accepted access
// - intr_status            in   1          level, status bit 3
// - evt_mdpe/sta/rta/rma/sse/dpe  in 1 each  1-cycle set pulses for status bits 8,11,12,13,14,15
// - cmd_io/mem/bus_master  out  1 each     command bits 0,1,2
// - cmd_serr_en/perr_resp/intr_disable out 1 each  command bits 8,6,10
// - bar_base               out  NUM_BARS*32  BAR k at [32k+31:32k], low BAR_SIZE_LOG2 bits 0
// - msi_enable             out  1          MSI control bit 0
// - msi_num_vectors_log2   out  3          effective Multiple Message Enable
// - msi_address            out  64         {upper,lower[31:2],2'b00}
// - msi_data               out  16         MSI data
// BEHAVIOUR
// - Reset: all outputs 0; cfg_read_val 0; cfg_ack 0; subsystem IDs = {DEVICE_ID,VENDOR_ID}. Reset mid-access: ack suppressed.
// - Latency 1: access at edge N -> cfg_ack and cfg_read_val at N+1; writes take effect at N+1, read-after-write on consecutive cycles returns new value.
// - Back-to-back: cfg_enable held k cycles -> k acks; no stall, no backpressure.
// - Writes: only byte lanes with cfg_byte_en=1 alter RW fields; RO/reserved bits ignore writes; byte_en=0 write still acks.
// - Read map: 0x00 IDs; 0x01 {status,command}; 0x02 {CLASS_CODE,REVISION}; 0x03 {BIST 0,hdr 0x00,lat_timer[7:3],cacheline};
//   0x04-0x09 BARs (unimplemented = 0); 0x0b subsystem (RO); 0x0d cap ptr 0x40; 0x0f {0,0,INTx pin 0x01,int_line RW};
//   0x10 MSI hdr {ctrl,next 0x00,id 0x05}; 0x11 addr lo; 0x12 addr hi; 0x13 data[15:0]; all else 0.
// - Command RW bits: 0,1,2,3,4,6,8,9,10; other bits read 0.
// - Status: bit 4 caps=1, bit 3 = intr_status live; bits 8,11-15 sticky, set by evt pulse, cleared by writing 1 (W1C) on enabled lane.
//   Set pulse and W1C in same cycle -> bit stays 1.
// - BAR: bits [31:BAR_SIZE_LOG2] RW, [BAR_SIZE_LOG2-1:4] read 0, [3:0]=0 (mem, 32-bit, non-prefetch); write 0xffffffff reads back size mask.
// - MSI ctrl: bit 0 enable RW; [3:1] MMC=MSI_VECTORS_LOG2 RO; [6:4] MME RW, write value > MMC stored as MMC; bit 7 64-bit=1; rest 0.
// - msi_num_vectors_log2 = MME; msi outputs are register values independent of msi_enable.
// TESTING
// - Reset, read 0x00/0x02/0x10 -> 0x11e81234, 0xff00000a, 0x00800005 (MSI_VECTORS_LOG2=0); ack exactly 1 cycle after request.
// - NUM_BARS=2, BAR_SIZE_LOG2=12: write 0xffffffff to 0x04, read -> 0xfffff000; write 0xfebc1234 -> 0xfebc1000; 0x06 reads 0.
// - Command write 0x00000406 with byte_en 4'b0001 -> reads 0x0006 in command; byte_en 4'b0011 -> 0x0406, cmd_intr_disable=1.
// - evt_rma pulse -> status bit 13 set; W1C write 0x20000000 be 4'b1000 -> clear; W1C coincident with evt_rma -> stays set.
// - MSI_VECTORS_LOG2=2: write ctrl MME=5 -> reads MME=2, msi_num_vectors_log2=2; 0x11 write 0xfee00003 -> reads 0xfee00000.
// - 4 back-to-back reads with cfg_enable held -> 4 acks; assert rst mid-burst -> ack 0, all RW regs default.

Source files
------------

// File: rtl/pci_cfg_space.sv
// Type-0 PCI configuration space: byte-enabled dword accesses with a one-cycle ack,
// memory BARs with sizing, W1C status bits and a 64-bit multi-vector MSI capability.
module pci_cfg_space #(
    parameter logic [15:0] VENDOR_ID        = 16'h1234,
    parameter logic [15:0] DEVICE_ID        = 16'h11e8,
    parameter logic [7:0]  REVISION         = 8'h0a,
    parameter logic [23:0] CLASS_CODE       = 24'hff0000,
    parameter int          NUM_BARS         = 1,
    parameter int          BAR_SIZE_LOG2    = 12,
    parameter int          MSI_VECTORS_LOG2 = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_enable,
    input  logic                     cfg_iswrite,
    input  logic [5:0]               cfg_offset,
    input  logic [3:0]               cfg_byte_en,
    input  logic [31:0]              cfg_write_val,
    output logic [31:0]              cfg_read_val,
    output logic                     cfg_ack,
    input  logic                     intr_status,
    input  logic                     evt_mdpe,
    input  logic                     evt_sta,
    input  logic                     evt_rta,
    input  logic                     evt_rma,
    input  logic                     evt_sse,
    input  logic                     evt_dpe,
    output logic                     cmd_io,
    output logic                     cmd_mem,
    output logic                     cmd_bus_master,
    output logic                     cmd_serr_en,
    output logic                     cmd_perr_resp,
    output logic                     cmd_intr_disable,
    output logic [NUM_BARS*32-1:0]   bar_base,
    output logic                     msi_enable,
    output logic [2:0]               msi_num_vectors_log2,
    output logic [63:0]              msi_address,
    output logic [15:0]              msi_data
);

    localparam logic [31:0] BAR_MASK   = ~((32'd1 << BAR_SIZE_LOG2) - 32'd1);
    localparam logic [2:0]  MMC        = 3'(MSI_VECTORS_LOG2);
    localparam logic [15:0] CMD_MASK   = 16'h075f;
    // High status byte: bits 8 and 11..15 are sticky event flags.
    localparam logic [7:0]  STS_STICKY = 8'hf9;

    logic [15:0] cmd_q;
    logic [7:0]  sts_q;
    logic [4:0]  lat_q;
    logic [7:0]  cache_q;
    logic [7:0]  int_line_q;
    logic [31:0] bar_q [NUM_BARS];
    logic        msi_en_q;
    logic [2:0]  mme_q;
    logic [31:2] msi_lo_q;
    logic [31:0] msi_hi_q;
    logic [15:0] msi_data_q;
    logic        ack_q;
    logic [31:0] rd_q;

    logic        wr;
    logic [31:0] wm;
    logic [7:0]  sts_set;
    logic [7:0]  sts_clr;
    logic [7:0]  sts_d;
    logic [15:0] status;
    logic [15:0] msi_ctrl;
    logic [2:0]  mme_wr;
    logic [31:0] rd_mux;

    assign wr      = cfg_enable & cfg_iswrite;
    assign wm      = {{8{cfg_byte_en[3]}}, {8{cfg_byte_en[2]}},
                      {8{cfg_byte_en[1]}}, {8{cfg_byte_en[0]}}};
    assign sts_set = {evt_dpe, evt_sse, evt_rma, evt_rta, evt_sta, 2'b00, evt_mdpe};
    assign sts_clr = (wr && cfg_offset == 6'h01 && cfg_byte_en[3]) ? cfg_write_val[31:24] : 8'h00;
    // A set pulse wins over a coincident W1C.
    assign sts_d   = (sts_set | (sts_q & ~sts_clr)) & STS_STICKY;
    assign status  = {sts_q, 3'b000, 1'b1, intr_status, 3'b000};
    assign msi_ctrl = {8'h00, 1'b1, mme_q, MMC, msi_en_q};
    assign mme_wr  = (cfg_write_val[22:20] > MMC) ? MMC : cfg_write_val[22:20];

    always_comb begin
        rd_mux = '0;
        case (cfg_offset)
            6'h00: rd_mux = {DEVICE_ID, VENDOR_ID};
            6'h01: rd_mux = {status, cmd_q};
            6'h02: rd_mux = {CLASS_CODE, REVISION};
            6'h03: rd_mux = {16'h0000, lat_q, 3'b000, cache_q};
            6'h0b: rd_mux = {DEVICE_ID, VENDOR_ID};
            6'h0d: rd_mux = 32'h0000_0040;
            6'h0f: rd_mux = {16'h0000, 8'h01, int_line_q};
            6'h10: rd_mux = {msi_ctrl, 8'h00, 8'h05};
            6'h11: rd_mux = {msi_lo_q, 2'b00};
            6'h12: rd_mux = msi_hi_q;
            6'h13: rd_mux = {16'h0000, msi_data_q};
            default: begin
                for (int k = 0; k < NUM_BARS; k++) begin
                    if (cfg_offset == 6'(4 + k)) rd_mux = bar_q[k];
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_q      <= '0;
            sts_q      <= '0;
            lat_q      <= '0;
            cache_q    <= '0;
            int_line_q <= '0;
            for (int k = 0; k < NUM_BARS; k++) bar_q[k] <= '0;
            msi_en_q   <= 1'b0;
            mme_q      <= '0;
            msi_lo_q   <= '0;
            msi_hi_q   <= '0;
            msi_data_q <= '0;
            ack_q      <= 1'b0;
            rd_q       <= '0;
        end else begin
            ack_q <= cfg_enable;
            if (cfg_enable) rd_q <= cfg_iswrite ? 32'h0 : rd_mux;
            sts_q <= sts_d;
            if (wr) begin
                case (cfg_offset)
                    6'h01: cmd_q <= ((cmd_q & ~wm[15:0]) | (cfg_write_val[15:0] & wm[15:0])) & CMD_MASK;
                    6'h03: begin
                        lat_q   <= (lat_q & ~wm[15:11]) | (cfg_write_val[15:11] & wm[15:11]);
                        cache_q <= (cache_q & ~wm[7:0]) | (cfg_write_val[7:0] & wm[7:0]);
                    end
                    6'h0f: int_line_q <= (int_line_q & ~wm[7:0]) | (cfg_write_val[7:0] & wm[7:0]);
                    6'h10: begin
                        if (cfg_byte_en[2]) begin
                            msi_en_q <= cfg_write_val[16];
                            mme_q    <= mme_wr;
                        end
                    end
                    6'h11: msi_lo_q   <= (msi_lo_q & ~wm[31:2]) | (cfg_write_val[31:2] & wm[31:2]);
                    6'h12: msi_hi_q   <= (msi_hi_q & ~wm) | (cfg_write_val & wm);
                    6'h13: msi_data_q <= (msi_data_q & ~wm[15:0]) | (cfg_write_val[15:0] & wm[15:0]);
                    default: ;
                endcase
                for (int k = 0; k < NUM_BARS; k++) begin
                    if (cfg_offset == 6'(4 + k))
                        bar_q[k] <= ((bar_q[k] & ~wm) | (cfg_write_val & wm)) & BAR_MASK;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_BARS; g++) begin : g_bar
        assign bar_base[32*g +: 32] = bar_q[g];
    end

    assign cfg_ack              = ack_q;
    assign cfg_read_val         = rd_q;
    assign cmd_io               = cmd_q[0];
    assign cmd_mem              = cmd_q[1];
    assign cmd_bus_master       = cmd_q[2];
    assign cmd_perr_resp        = cmd_q[6];
    assign cmd_serr_en          = cmd_q[8];
    assign cmd_intr_disable     = cmd_q[10];
    assign msi_enable           = msi_en_q;
    assign msi_num_vectors_log2 = mme_q;
    assign msi_address          = {msi_hi_q, msi_lo_q, 2'b00};
    assign msi_data             = msi_data_q;

endmodule

// File: tb/tb_pci_cfg_space.sv
// Bench for pci_cfg_space: vector table applied back-to-back, scoreboarded read data,
// per-cycle ack timing, plus status W1C, burst and mid-burst reset sequences.
module tb_pci_cfg_space;

    localparam int NB  = 2;
    localparam int MMC = 2;
    localparam logic [31:0] MSI_HDR_RST = 32'h0080_0005 | (32'(MMC) << 17);

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            cfg_enable = 1'b0;
    logic            cfg_iswrite = 1'b0;
    logic [5:0]      cfg_offset = '0;
    logic [3:0]      cfg_byte_en = '0;
    logic [31:0]     cfg_write_val = '0;
    logic [31:0]     cfg_read_val;
    logic            cfg_ack;
    logic            intr_status = 1'b0;
    logic            evt_mdpe = 1'b0, evt_sta = 1'b0, evt_rta = 1'b0;
    logic            evt_rma = 1'b0, evt_sse = 1'b0, evt_dpe = 1'b0;
    logic            cmd_io, cmd_mem, cmd_bus_master, cmd_serr_en, cmd_perr_resp, cmd_intr_disable;
    logic [NB*32-1:0] bar_base;
    logic            msi_enable;
    logic [2:0]      msi_num_vectors_log2;
    logic [63:0]     msi_address;
    logic [15:0]     msi_data;

    pci_cfg_space #(
        .NUM_BARS(NB), .BAR_SIZE_LOG2(12), .MSI_VECTORS_LOG2(MMC)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_enable(cfg_enable), .cfg_iswrite(cfg_iswrite), .cfg_offset(cfg_offset),
        .cfg_byte_en(cfg_byte_en), .cfg_write_val(cfg_write_val),
        .cfg_read_val(cfg_read_val), .cfg_ack(cfg_ack),
        .intr_status(intr_status),
        .evt_mdpe(evt_mdpe), .evt_sta(evt_sta), .evt_rta(evt_rta),
        .evt_rma(evt_rma), .evt_sse(evt_sse), .evt_dpe(evt_dpe),
        .cmd_io(cmd_io), .cmd_mem(cmd_mem), .cmd_bus_master(cmd_bus_master),
        .cmd_serr_en(cmd_serr_en), .cmd_perr_resp(cmd_perr_resp),
        .cmd_intr_disable(cmd_intr_disable),
        .bar_base(bar_base),
        .msi_enable(msi_enable), .msi_num_vectors_log2(msi_num_vectors_log2),
        .msi_address(msi_address), .msi_data(msi_data)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_errors = 0;
    int ack_cnt  = 0;
    logic ack_due = 1'b0;
    // Entry: {check read value, offset, expected read data}
    logic [38:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: ack must follow every accepted access by exactly one cycle
    always @(posedge clk) ack_due = cfg_enable && rst;

    always @(negedge clk) begin : mon
        logic [38:0] ent;
        n_checks++;
        if (cfg_ack !== (ack_due && rst)) begin
            n_errors++;
            $display("FAIL ack_timing: got %b expected %b at %0t", cfg_ack, ack_due && rst, $time);
        end
        if (cfg_ack === 1'b1) begin
            ack_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_ack: got ack with empty queue expected none");
            end else begin
                ent = exp_q.pop_front();
                if (ent[38]) begin
                    n_checks++;
                    if (cfg_read_val !== ent[31:0]) begin
                        n_errors++;
                        $display("FAIL read_val off=%h: got %h expected %h", ent[37:32], cfg_read_val, ent[31:0]);
                    end
                end
            end
        end
    end

    // Driver tasks
    task automatic access(input logic wr, input logic [5:0] off, input logic [3:0] be,
                          input logic [31:0] val, input logic [31:0] exp);
        @(negedge clk); #1;
        cfg_enable = 1'b1; cfg_iswrite = wr; cfg_offset = off;
        cfg_byte_en = be; cfg_write_val = val;
        exp_q.push_back({~wr, off, exp});
    endtask

    task automatic idle();
        @(negedge clk); #1;
        cfg_enable = 1'b0; cfg_iswrite = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic rd(input logic [5:0] off, input logic [31:0] exp);
        access(1'b0, off, 4'h0, 32'h0, exp);
        idle();
        drain();
    endtask

    task automatic wrt(input logic [5:0] off, input logic [3:0] be, input logic [31:0] val);
        access(1'b1, off, be, val, 32'h0);
        idle();
        drain();
    endtask

    typedef struct {
        logic        wr;
        logic [5:0]  off;
        logic [3:0]  be;
        logic [31:0] wv;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[64];
    int   nv = 0;

    task automatic add(input logic wr, input logic [5:0] off, input logic [3:0] be,
                       input logic [31:0] wv, input logic [31:0] exp);
        vecs[nv] = '{wr, off, be, wv, exp};
        nv++;
    endtask

    initial begin
        // Vector table: reads follow writes on consecutive cycles
        add(0, 6'h00, 4'h0, 32'h0, 32'h11e8_1234);
        add(0, 6'h02, 4'h0, 32'h0, 32'hff00_000a);
        add(0, 6'h10, 4'h0, 32'h0, MSI_HDR_RST);
        add(0, 6'h03, 4'h0, 32'h0, 32'h0000_0000);
        add(0, 6'h0b, 4'h0, 32'h0, 32'h11e8_1234);
        add(0, 6'h0d, 4'h0, 32'h0, 32'h0000_0040);
        add(0, 6'h0f, 4'h0, 32'h0, 32'h0000_0100);
        add(0, 6'h01, 4'h0, 32'h0, 32'h0010_0000);
        add(1, 6'h04, 4'hf, 32'hffff_ffff, 32'h0);
        add(0, 6'h04, 4'h0, 32'h0, 32'hffff_f000);
        add(1, 6'h04, 4'hf, 32'hfebc_1234, 32'h0);
        add(0, 6'h04, 4'h0, 32'h0, 32'hfebc_1000);
        add(0, 6'h06, 4'h0, 32'h0, 32'h0000_0000);
        add(0, 6'h05, 4'h0, 32'h0, 32'h0000_0000);
        add(1, 6'h06, 4'hf, 32'hffff_ffff, 32'h0);
        add(0, 6'h06, 4'h0, 32'h0, 32'h0000_0000);
        add(1, 6'h01, 4'b0001, 32'h0000_0406, 32'h0);
        add(0, 6'h01, 4'h0, 32'h0, 32'h0010_0006);
        add(1, 6'h01, 4'b0011, 32'h0000_0406, 32'h0);
        add(0, 6'h01, 4'h0, 32'h0, 32'h0010_0406);
        add(1, 6'h10, 4'hf, 32'h00d1_0001, 32'h0);
        add(0, 6'h10, 4'h0, 32'h0, MSI_HDR_RST | 32'h0021_0000);
        add(1, 6'h11, 4'hf, 32'hfee0_0003, 32'h0);
        add(0, 6'h11, 4'h0, 32'h0, 32'hfee0_0000);
        add(1, 6'h12, 4'hf, 32'h1234_5678, 32'h0);
        add(0, 6'h12, 4'h0, 32'h0, 32'h1234_5678);
        add(1, 6'h13, 4'hf, 32'habcd_5678, 32'h0);
        add(0, 6'h13, 4'h0, 32'h0, 32'h0000_5678);
        add(1, 6'h03, 4'hf, 32'hffff_ffff, 32'h0);
        add(0, 6'h03, 4'h0, 32'h0, 32'h0000_f8ff);
        add(1, 6'h0f, 4'hf, 32'hffff_ffff, 32'h0);
        add(0, 6'h0f, 4'h0, 32'h0, 32'h0000_01ff);
        add(1, 6'h00, 4'hf, 32'hffff_ffff, 32'h0);
        add(0, 6'h00, 4'h0, 32'h0, 32'h11e8_1234);
        add(1, 6'h3f, 4'hf, 32'hffff_ffff, 32'h0);
        add(0, 6'h3f, 4'h0, 32'h0, 32'h0000_0000);
        add(1, 6'h10, 4'b0100, 32'h0030_0000, 32'h0);
        add(0, 6'h10, 4'h0, 32'h0, MSI_HDR_RST | 32'h0020_0000);
        add(1, 6'h01, 4'b0000, 32'hffff_ffff, 32'h0);
        add(0, 6'h01, 4'h0, 32'h0, 32'h0010_0406);
        add(1, 6'h04, 4'b1000, 32'h00ff_ffff, 32'h0);
        add(0, 6'h04, 4'h0, 32'h0, 32'h00bc_1000);
        add(1, 6'h05, 4'hf, 32'h8000_0000, 32'h0);
        add(0, 6'h05, 4'h0, 32'h0, 32'h8000_0000);

        // Reset block
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_ack", {63'h0, cfg_ack}, 64'h0);
        check("reset_read_val", {32'h0, cfg_read_val}, 64'h0);
        check("reset_bar_base", bar_base, 64'h0);
        check("reset_msi_address", msi_address, 64'h0);
        check("reset_cmd", {58'h0, cmd_io, cmd_mem, cmd_bus_master, cmd_serr_en,
                            cmd_perr_resp, cmd_intr_disable}, 64'h0);
        rst = 1'b1;

        for (int i = 0; i < nv; i++)
            access(vecs[i].wr, vecs[i].off, vecs[i].be, vecs[i].wv, vecs[i].exp);
        idle();
        drain();

        check("cmd_intr_disable", {63'h0, cmd_intr_disable}, 64'h1);
        check("cmd_mem_bm_io", {61'h0, cmd_mem, cmd_bus_master, cmd_io}, 64'h6);
        check("cmd_serr_perr", {62'h0, cmd_serr_en, cmd_perr_resp}, 64'h0);
        check("bar_base", bar_base, 64'h8000_0000_00bc_1000);
        check("msi_enable", {63'h0, msi_enable}, 64'h0);
        check("msi_num_vectors", {61'h0, msi_num_vectors_log2}, 64'h2);
        check("msi_address", msi_address, 64'h1234_5678_fee0_0000);
        check("msi_data", {48'h0, msi_data}, 64'h5678);

        // Status: event set, W1C, wrong-lane write, set/clear collision
        @(negedge clk); #1 evt_rma = 1'b1;
        @(negedge clk); #1 evt_rma = 1'b0;
        rd(6'h01, 32'h2010_0406);
        wrt(6'h01, 4'b1000, 32'h2000_0000);
        rd(6'h01, 32'h0010_0406);
        @(negedge clk); #1 evt_rma = 1'b1;
        @(negedge clk); #1 evt_rma = 1'b0;
        wrt(6'h01, 4'b0100, 32'h2000_0000);
        rd(6'h01, 32'h2010_0406);
        access(1'b1, 6'h01, 4'b1000, 32'h2000_0000, 32'h0);
        evt_rma = 1'b1;
        idle();
        evt_rma = 1'b0;
        drain();
        rd(6'h01, 32'h2010_0406);
        @(negedge clk); #1;
        {evt_mdpe, evt_sta, evt_rta, evt_rma, evt_sse, evt_dpe} = 6'b111111;
        intr_status = 1'b1;
        @(negedge clk); #1;
        {evt_mdpe, evt_sta, evt_rta, evt_rma, evt_sse, evt_dpe} = 6'b000000;
        rd(6'h01, 32'hf918_0406);
        wrt(6'h01, 4'b1100, 32'hffff_0000);
        rd(6'h01, 32'h0018_0406);
        intr_status = 1'b0;
        rd(6'h01, 32'h0010_0406);

        // Back-to-back burst of random-order reads
        ack_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 3))
                0: access(1'b0, 6'h00, 4'h0, 32'h0, 32'h11e8_1234);
                1: access(1'b0, 6'h02, 4'h0, 32'h0, 32'hff00_000a);
                2: access(1'b0, 6'h0d, 4'h0, 32'h0, 32'h0000_0040);
                default: access(1'b0, 6'h13, 4'h0, 32'h0, 32'h0000_5678);
            endcase
        end
        idle();
        drain();
        check("burst_ack_count", 64'(ack_cnt), 64'd4);

        // Reset asserted in the middle of a burst
        access(1'b0, 6'h00, 4'h0, 32'h0, 32'h11e8_1234);
        access(1'b0, 6'h01, 4'h0, 32'h0, 32'h0010_0406);
        access(1'b0, 6'h02, 4'h0, 32'h0, 32'hff00_000a);
        @(posedge clk); #2;
        rst = 1'b0;
        cfg_enable = 1'b0;
        exp_q.delete();
        @(negedge clk); #1;
        check("mid_reset_ack", {63'h0, cfg_ack}, 64'h0);
        check("mid_reset_bar", bar_base, 64'h0);
        check("mid_reset_msi", {msi_address[63:16], msi_data}, 64'h0);
        check("mid_reset_msi_ctl", {60'h0, msi_enable, msi_num_vectors_log2}, 64'h0);
        check("mid_reset_cmd", {58'h0, cmd_io, cmd_mem, cmd_bus_master, cmd_serr_en,
                                cmd_perr_resp, cmd_intr_disable}, 64'h0);
        @(negedge clk); #1;
        rst = 1'b1;
        rd(6'h01, 32'h0010_0000);
        rd(6'h03, 32'h0000_0000);
        rd(6'h0f, 32'h0000_0100);
        rd(6'h10, MSI_HDR_RST);
        rd(6'h04, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
